equation_checker: RTL

EQUATION_CHECKER -- requirements
Module: equation_checker

---
 rtl/eq_pkg.sv | 43 ++++
 rtl/eq_alu.sv | 37 +++
 rtl/equation_checker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the equation checker: FSM state encoding,
// equation-select (Mode) encodings and ALU operation codes.
package eq_pkg;

    // Equation selected by Mode, sampled when a round starts
    localparam logic [1:0] MODE_SQDIV  = 2'd0;   // (X/Z)*(X/Z) + Y/Z
    localparam logic [1:0] MODE_MULADD = 2'd1;   // X*Y + Z
    localparam logic [1:0] MODE_ADDMUL = 2'd2;   // (X+Y)*Z
    localparam logic [1:0] MODE_SUBDIV = 2'd3;   // X - Y/Z

    // Round sequencer states
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LD_X = 4'd1,
        S_WT_X = 4'd2,
        S_LD_Y = 4'd3,
        S_WT_Y = 4'd4,
        S_LD_Z = 4'd5,
        S_WT_Z = 4'd6,
        S_CYC0 = 4'd7,
        S_CYC1 = 4'd8,
        S_CYC2 = 4'd9,
        S_CMP  = 4'd10,
        S_DONE = 4'd11
    } state_t;

    // Operations the shared ALU can perform
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_MUL  = 3'd2,
        ALU_DIV  = 3'd3,
        ALU_PASS = 3'd4
    } alu_op_t;

    // True for the operand-entry states, where Start release aborts the round
    function automatic logic is_entry_state(input state_t s);
        return (s == S_LD_X) || (s == S_WT_X) ||
               (s == S_LD_Y) || (s == S_WT_Y) ||
               (s == S_LD_Z) || (s == S_WT_Z);
    endfunction

endpackage

// File: rtl/eq_alu.sv
// Combinational unsigned ALU for the equation checker. All results wrap
// modulo 2^WIDTH; division truncates, and a zero divisor returns all-ones
// and raises div_zero.
module eq_alu
    import eq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             div_zero
);

    // Select the requested operation; divide-by-zero is flagged, not trapped
    always_comb begin
        y        = '0;
        div_zero = 1'b0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_MUL:  y = a * b;
            ALU_DIV: begin
                if (b == '0) begin
                    y        = '1;
                    div_zero = 1'b1;
                end else begin
                    y = a / b;
                end
            end
            ALU_PASS: y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/equation_checker.sv
// Equation checker: the user enters X, Y and Z with Go presses while Start
// is held, the block evaluates the equation chosen by Mode over three ALU
// cycles and compares it with the target sampled from OngoingTimer.
// Optional feature: define EQ_TIMEOUT_EN to abort a round to DONE with
// timeout=1 when OngoingTimer reads 0 during operand entry.
module equation_checker
    import eq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMER_W = 7
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Go,
    input  logic               Start,
    input  logic [1:0]         Mode,
    input  logic [TIMER_W-1:0] OngoingTimer,
    input  logic [WIDTH-1:0]   DataIn,
    output logic               busy,
    output logic               done,
    output logic               correct,
    output logic [WIDTH-1:0]   result,
    output logic               div_err,
    output logic               timeout
);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] x_q,       x_d;
    logic [WIDTH-1:0] y_q,       y_d;
    logic [WIDTH-1:0] z_q,       z_d;
    logic [WIDTH-1:0] target_q,  target_d;
    logic [1:0]       mode_q,    mode_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             correct_q, correct_d;
    logic             div_err_q, div_err_d;
`ifdef EQ_TIMEOUT_EN
    logic             timeout_q, timeout_d;
`endif

    alu_op_t          alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_dz;
    logic [WIDTH-1:0] aux_y;
    logic             aux_dz;

    // Main ALU: one operation per compute cycle, written to the accumulator
    eq_alu #(.WIDTH(WIDTH)) u_alu_main (
        .op       (alu_op),
        .a        (alu_a),
        .b        (alu_b),
        .y        (alu_y),
        .div_zero (alu_dz)
    );

    // Second divider supplies Y/Z so mode 0 fits in three compute cycles
    eq_alu #(.WIDTH(WIDTH)) u_alu_aux (
        .op       (ALU_DIV),
        .a        (y_q),
        .b        (z_q),
        .y        (aux_y),
        .div_zero (aux_dz)
    );

    // Next-state, operand capture and ALU control for the round sequencer
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        target_d  = target_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        result_d  = result_q;
        correct_d = correct_q;
        div_err_d = div_err_q;
`ifdef EQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        alu_op    = ALU_PASS;
        alu_a     = acc_q;
        alu_b     = z_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d   = S_LD_X;
                    target_d  = WIDTH'(OngoingTimer);
                    mode_d    = Mode;
                    x_d       = '0;
                    y_d       = '0;
                    z_d       = '0;
                    acc_d     = '0;
                    result_d  = '0;
                    correct_d = 1'b0;
                    div_err_d = 1'b0;
`ifdef EQ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end

            S_LD_X, S_WT_X, S_LD_Y, S_WT_Y, S_LD_Z, S_WT_Z: begin
`ifdef EQ_TIMEOUT_EN
                if (OngoingTimer == '0) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    correct_d = 1'b0;
                end else
`endif
                if (!Start) begin
                    state_d   = S_IDLE;
                    correct_d = 1'b0;
                end else begin
                    case (state_q)
                        S_LD_X: if (Go) begin
                            x_d     = DataIn;
                            state_d = S_WT_X;
                        end
                        S_WT_X: if (!Go) state_d = S_LD_Y;
                        S_LD_Y: if (Go) begin
                            y_d     = DataIn;
                            state_d = S_WT_Y;
                        end
                        S_WT_Y: if (!Go) state_d = S_LD_Z;
                        S_LD_Z: if (Go) begin
                            z_d     = DataIn;
                            state_d = S_WT_Z;
                        end
                        S_WT_Z: if (!Go) state_d = S_CYC0;
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_CYC0: begin
                case (mode_q)
                    MODE_SQDIV: begin
                        alu_op = ALU_DIV;
                        alu_a  = x_q;
                        alu_b  = z_q;
                    end
                    MODE_MULADD: begin
                        alu_op = ALU_MUL;
                        alu_a  = x_q;
                        alu_b  = y_q;
                    end
                    MODE_ADDMUL: begin
                        alu_op = ALU_ADD;
                        alu_a  = x_q;
                        alu_b  = y_q;
                    end
                    MODE_SUBDIV: begin
                        alu_op = ALU_DIV;
                        alu_a  = y_q;
                        alu_b  = z_q;
                    end
                    default: alu_op = ALU_PASS;
                endcase
                acc_d     = alu_y;
                div_err_d = div_err_q | alu_dz;
                state_d   = S_CYC1;
            end

            S_CYC1: begin
                case (mode_q)
                    MODE_SQDIV: begin
                        alu_op = ALU_MUL;
                        alu_a  = acc_q;
                        alu_b  = acc_q;
                    end
                    MODE_MULADD: begin
                        alu_op = ALU_ADD;
                        alu_a  = acc_q;
                        alu_b  = z_q;
                    end
                    MODE_ADDMUL: begin
                        alu_op = ALU_MUL;
                        alu_a  = acc_q;
                        alu_b  = z_q;
                    end
                    MODE_SUBDIV: begin
                        alu_op = ALU_SUB;
                        alu_a  = x_q;
                        alu_b  = acc_q;
                    end
                    default: alu_op = ALU_PASS;
                endcase
                acc_d     = alu_y;
                div_err_d = div_err_q | alu_dz;
                state_d   = S_CYC2;
            end

            S_CYC2: begin
                if (mode_q == MODE_SQDIV) begin
                    alu_op    = ALU_ADD;
                    alu_a     = acc_q;
                    alu_b     = aux_y;
                    div_err_d = div_err_q | aux_dz;
                end else begin
                    alu_op = ALU_PASS;
                    alu_a  = acc_q;
                end
                acc_d   = alu_y;
                state_d = S_CMP;
            end

            S_CMP: begin
                result_d  = acc_q;
                correct_d = (acc_q == target_q) && !div_err_q;
                state_d   = S_DONE;
            end

            S_DONE: begin
                if (!Start) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared immediately by Reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            target_q  <= '0;
            mode_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            correct_q <= 1'b0;
            div_err_q <= 1'b0;
`ifdef EQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            target_q  <= target_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            correct_q <= correct_d;
            div_err_q <= div_err_d;
`ifdef EQ_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign correct = correct_q;
    assign result  = result_q;
    assign div_err = div_err_q;
`ifdef EQ_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
